elixirchip_es1_spu_stream_sink: RTL and testbench

ELIXIRCHIP_ES1_SPU_STREAM_SINK -- requirements
Module: elixirchip_es1_spu_stream_sink

---
 rtl/elixirchip_es1_spu_pkg.sv | 31 +++
 rtl/elixirchip_es1_spu_sink_fifo.sv | 55 +++++
 rtl/sva_elixirchip_es1_spu_stream_sink.sv | 54 +++++
 rtl/elixirchip_es1_spu_stream_sink.sv | 79 +++++++
 tb/tb_elixirchip_es1_spu_stream_sink.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// elixirchip_es1_spu_pkg: shared SPU constants, beat type and parameter checks
package elixirchip_es1_spu_pkg;

  localparam string SPU_DEVICE_RTL         = "RTL";
  localparam string SPU_DEVICE_SPARTAN7    = "SPARTAN7";
  localparam string SPU_DEVICE_ARTIX7      = "ARTIX7";
  localparam string SPU_DEVICE_KINTEX7     = "KINTEX7";
  localparam string SPU_DEVICE_ULTRASCALE  = "ULTRASCALE";
  localparam string SPU_DEVICE_ULTRASCALE_PLUS = "ULTRASCALE_PLUS";

  localparam string SPU_TRUE  = "true";
  localparam string SPU_FALSE = "false";

  // Widest payload any SPU stream carries; narrower streams use the low bits.
  localparam int SPU_AXI4S_MAX_DATA_BITS = 64;

  typedef struct packed {
    logic [SPU_AXI4S_MAX_DATA_BITS-1:0] data;
    logic                               last;
  } spu_axi4s_beat_t;

  function automatic bit spu_device_ok(input string d);
    return d == SPU_DEVICE_RTL || d == SPU_DEVICE_SPARTAN7 || d == SPU_DEVICE_ARTIX7 ||
           d == SPU_DEVICE_KINTEX7 || d == SPU_DEVICE_ULTRASCALE || d == SPU_DEVICE_ULTRASCALE_PLUS;
  endfunction

  function automatic bit spu_flag_ok(input string f);
    return f == SPU_TRUE || f == SPU_FALSE;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_sink_fifo.sv
// elixirchip_es1_spu_sink_fifo: first-word-fall-through synchronous FIFO with occupancy count
//   reset    in   sync active-high, clears both pointers (storage is not reset)
//   clk      in   clock
//   wr_en    in   write wr_data at the tail (caller guarantees !full)
//   wr_data  in   WIDTH-bit word
//   rd_en    in   drop the head word (caller guarantees rd_valid)
//   rd_data  out  head word, valid while rd_valid
//   rd_valid out  FIFO not empty
//   full     out  FIFO holds DEPTH words
//   count    out  occupancy 0..DEPTH
module elixirchip_es1_spu_sink_fifo
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int PTR_BITS = 2
) (
  input  logic                reset,
  input  logic                clk,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic [PTR_BITS:0]   count
);

  localparam int DEPTH = 2 ** PTR_BITS;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  always_comb begin
    wr_ptr_d = reset ? '0 : wr_ptr_q + (PTR_BITS+1)'(wr_en);
    rd_ptr_d = reset ? '0 : rd_ptr_q + (PTR_BITS+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[PTR_BITS-1:0]] <= wr_data;
  end

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                    (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
  assign rd_valid = wr_ptr_q != rd_ptr_q;
  assign rd_data  = mem_q[rd_ptr_q[PTR_BITS-1:0]];

endmodule

// File: rtl/sva_elixirchip_es1_spu_stream_sink.sv
// sva_elixirchip_es1_spu_stream_sink: occupancy bound, AXI4-Stream hold and count bookkeeping checks
//   all ports are inputs observing the bound stream sink
module sva_elixirchip_es1_spu_stream_sink
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PTR_BITS  = 2
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 cke,
  input logic                 s_valid,
  input logic [DATA_BITS-1:0] m_axi4s_tdata,
  input logic                 m_axi4s_tlast,
  input logic                 m_axi4s_tvalid,
  input logic                 m_axi4s_tready,
  input logic [PTR_BITS:0]    count
);

  localparam int DEPTH = 2 ** PTR_BITS;

  logic wr, rd;

  always_comb begin
    wr = cke && s_valid && (int'(count) != DEPTH);
    rd = m_axi4s_tvalid && m_axi4s_tready;
  end

  a_count_max : assert property (@(posedge clk) disable iff (reset) int'(count) <= DEPTH);

  a_valid_count : assert property (@(posedge clk) disable iff (reset) m_axi4s_tvalid == (count != '0));

  a_hold : assert property (@(posedge clk) disable iff (reset)
    m_axi4s_tvalid && !m_axi4s_tready |=> m_axi4s_tvalid && $stable(m_axi4s_tdata) && $stable(m_axi4s_tlast));

  a_count_step : assert property (@(posedge clk) disable iff (reset)
    !$past(reset) |-> int'(count) == int'($past(count)) + int'($past(wr)) - int'($past(rd)));

endmodule

bind elixirchip_es1_spu_stream_sink sva_elixirchip_es1_spu_stream_sink #(
  .DATA_BITS (DATA_BITS),
  .PTR_BITS  (PTR_BITS)
) u_sva (
  .clk            (clk),
  .reset          (reset),
  .cke            (cke),
  .s_valid        (s_valid),
  .m_axi4s_tdata  (m_axi4s_tdata),
  .m_axi4s_tlast  (m_axi4s_tlast),
  .m_axi4s_tvalid (m_axi4s_tvalid),
  .m_axi4s_tready (m_axi4s_tready),
  .count          (count)
);

// File: rtl/elixirchip_es1_spu_stream_sink.sv
// elixirchip_es1_spu_stream_sink: converts an SPU op pipeline result into AXI4-Stream with cke backpressure
//   reset           in   sync active-high
//   clk             in   clock
//   cke             out  registered clock enable for all upstream SPU op stages
//   s_data/s_last   in   result beat from the last op stage
//   s_valid         in   result valid (only accepted while cke=1)
//   m_axi4s_*       out/in AXI4-Stream master (tdata, tlast, tvalid, tready)
//   count           out  FIFO occupancy 0..DEPTH
//   overflow        out  sticky: a beat arrived while the FIFO was full
module elixirchip_es1_spu_stream_sink
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    DATA_BITS  = 8,
  parameter int    PTR_BITS   = 2,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                 reset,
  input  logic                 clk,
  output logic                 cke,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_last,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_axi4s_tdata,
  output logic                 m_axi4s_tlast,
  output logic                 m_axi4s_tvalid,
  input  logic                 m_axi4s_tready,
  output logic [PTR_BITS:0]    count,
  output logic                 overflow
);

  localparam int DEPTH = 2 ** PTR_BITS;
  localparam logic [PTR_BITS+1:0] DEPTH_W = (PTR_BITS+2)'(DEPTH);

  if (PTR_BITS < 1 || !spu_device_ok(DEVICE) || !spu_flag_ok(SIMULATION) || !spu_flag_ok(DEBUG)) begin : g_bad_param
    $error("elixirchip_es1_spu_stream_sink: illegal PTR_BITS/DEVICE/SIMULATION/DEBUG");
  end

  logic                push, wr_en, rd_en, full;
  logic                cke_q, cke_d;
  logic                overflow_q, overflow_d;
  logic [PTR_BITS+1:0] count_next;

  // push reads the cke port so that an externally forced enable still lands here.
  always_comb begin
    push       = cke && s_valid;
    wr_en      = push && !full;
    rd_en      = m_axi4s_tvalid && m_axi4s_tready;
    count_next = {1'b0, count} + (PTR_BITS+2)'(wr_en) - (PTR_BITS+2)'(rd_en);
    // Stall one beat early: the registered cke lets exactly one more push in after the decision.
    cke_d      = !reset && (count_next < DEPTH_W);
    overflow_d = !reset && (overflow_q || (push && full));
  end

  always_ff @(posedge clk) begin
    cke_q      <= cke_d;
    overflow_q <= overflow_d;
  end

  assign cke      = cke_q;
  assign overflow = overflow_q;

  elixirchip_es1_spu_sink_fifo #(
    .WIDTH    (DATA_BITS + 1),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .reset    (reset),
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_data  ({s_last, s_data}),
    .rd_en    (rd_en),
    .rd_data  ({m_axi4s_tlast, m_axi4s_tdata}),
    .rd_valid (m_axi4s_tvalid),
    .full     (full),
    .count    (count)
  );

endmodule

// File: tb/tb_elixirchip_es1_spu_stream_sink.sv
// tb_elixirchip_es1_spu_stream_sink: random and directed stimulus against a queue reference model
module tb_elixirchip_es1_spu_stream_sink;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cke;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid;
  logic [7:0] m_axi4s_tdata;
  logic       m_axi4s_tlast;
  logic       m_axi4s_tvalid;
  logic       m_axi4s_tready;
  logic [2:0] count;
  logic       overflow;

  always #5 clk = ~clk;

  elixirchip_es1_spu_stream_sink #(
    .DATA_BITS (8),
    .PTR_BITS  (2)
  ) dut (
    .reset          (reset),
    .clk            (clk),
    .cke            (cke),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_valid        (s_valid),
    .m_axi4s_tdata  (m_axi4s_tdata),
    .m_axi4s_tlast  (m_axi4s_tlast),
    .m_axi4s_tvalid (m_axi4s_tvalid),
    .m_axi4s_tready (m_axi4s_tready),
    .count          (count),
    .overflow       (overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [8:0] q[$];
  logic [8:0] src[$];
  int         idx;
  int         got_n;
  logic       cke_m = 1'b0;
  logic       ov_m = 1'b0;
  logic       forced = 1'b0;
  logic       cke_s;
  logic [7:0] ff [5] = '{8'd0, 8'd255, 8'd1, 8'd254, 8'd5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic push, pop, full;
    @(negedge clk);
    if (!forced) chk("cke", 32'(cke), 32'(cke_m));
    chk("count", 32'(count), q.size());
    chk("tvalid", 32'(m_axi4s_tvalid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(ov_m));
    if (q.size() != 0) begin
      chk("tdata", 32'(m_axi4s_tdata), 32'(q[0][7:0]));
      chk("tlast", 32'(m_axi4s_tlast), 32'(q[0][8]));
    end
    cke_s = cke;
    @(posedge clk);
    if (reset) begin
      q.delete();
      cke_m = 1'b0;
      ov_m  = 1'b0;
    end else begin
      push = (forced || cke_m) && s_valid;
      pop  = (q.size() != 0) && m_axi4s_tready;
      full = q.size() == DEPTH;
      if (pop) begin
        void'(q.pop_front());
        got_n++;
      end
      if (push && full) ov_m = 1'b1;
      else if (push) q.push_back({s_last, s_data});
      cke_m = q.size() < DEPTH;
    end
    #1;
  endtask

  task automatic send(input logic ready, input bit gaps = 0);
    m_axi4s_tready = ready;
    s_valid = (idx < src.size()) && (!gaps || $urandom_range(1) == 1);
    if (s_valid) {s_last, s_data} = src[idx];
    else {s_last, s_data} = 9'($urandom);
    tick();
    if (cke_s && s_valid) idx++;
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_axi4s_tready = 1'b0;
    idx = 0;
    got_n = 0;
    @(posedge clk);
    #1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("cke_rise", 32'(cke), 32'd1);

    src.delete(); idx = 0; got_n = 0;
    foreach (ff[i]) src.push_back({1'b0, ff[i]});
    for (int c = 0; c < 8; c++) begin
      send(1'b1);
      chk("ff_cke", 32'(cke_s), 32'd1);
      chk("ff_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    chk("ff_rx", got_n, 5);

    src.delete(); idx = 0; got_n = 0;
    for (int i = 1; i <= 5; i++) src.push_back({1'b0, 8'(i * 10)});
    repeat (6) send(1'b0);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_cke", 32'(cke), 32'd0);
    chk("bp_ovf", 32'(overflow), 32'd0);
    send(1'b1);
    chk("rel_count", 32'(count), 32'd3);
    chk("rel_cke", 32'(cke), 32'd1);
    for (int c = 0; c < 20 && got_n < 5; c++) send(1'b1);
    chk("rel_rx", got_n, 5);

    src.delete(); idx = 0; got_n = 0;
    for (int i = 0; i < 20; i++) src.push_back({i == 19, 8'($urandom)});
    for (int c = 0; c < 200 && got_n < 20; c++) send(1'($urandom_range(1)), 1);
    chk("wrap_rx", got_n, 20);
    chk("wrap_sent", idx, 20);

    src.delete(); idx = 0;
    for (int i = 0; i < 4; i++) src.push_back({1'b0, 8'(8'hA0 + i)});
    repeat (6) send(1'b0);
    chk("ovf_pre", 32'(count), 32'd4);
    forced = 1'b1;
    force dut.cke = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hEE;
    s_last = 1'b1;
    m_axi4s_tready = 1'b0;
    tick();
    release dut.cke;
    forced = 1'b0;
    s_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    got_n = 0;
    repeat (8) send(1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_rx", got_n, 4);

    s_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    src.delete(); idx = 0;
    for (int i = 0; i < 3; i++) src.push_back({1'b0, 8'(8'h30 + i)});
    repeat (3) send(1'b0);
    chk("mid_count", 32'(count), 32'd3);
    reset = 1'b1;
    send(1'b0);
    reset = 1'b0;
    chk("mid_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("mid_count0", 32'(count), 32'd0);
    chk("mid_cke0", 32'(cke), 32'd0);
    send(1'b0);
    chk("mid_cke1", 32'(cke), 32'd1);

    for (int c = 0; c < 300; c++) begin
      s_valid = 1'($urandom_range(1));
      s_data = 8'($urandom);
      s_last = 1'($urandom_range(1));
      m_axi4s_tready = $urandom_range(3) < (c < 150 ? 1 : 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
